// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-port ALU sharing arbiter: FSM encoding,
// default widths and requester index constants.
package alu_arb_pkg;

  localparam int WIDTH_DEF  = 32;
  localparam int ALUC_W_DEF = 4;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant: a lone requester wins, on contention the
// requester that did not win last time wins.
module rr_arb2
  import alu_arb_pkg::*;
(
  input  logic [1:0] req_valid,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant
);

  // Grant decode from the current request pattern
  always_comb begin
    grant_valid = 1'b0;
    grant       = REQ0;
    case (req_valid)
      2'b01: begin
        grant_valid = 1'b1;
        grant       = REQ0;
      end
      2'b10: begin
        grant_valid = 1'b1;
        grant       = REQ1;
      end
      2'b11: begin
        grant_valid = 1'b1;
        grant       = ~last_grant;
      end
      default: begin
        grant_valid = 1'b0;
        grant       = REQ0;
      end
    endcase
  end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one combinational ALU between two requesters with round-robin
// arbitration. Optional grant counters are enabled by ALU_ARB_STATS_EN.
module alu_share_arb
  import alu_arb_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int ALUC_W = ALUC_W_DEF
) (
  input  logic                  clk,
  input  logic                  clrn,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [2*WIDTH-1:0]    req_x,
  input  logic [2*WIDTH-1:0]    req_y,
  input  logic [2*ALUC_W-1:0]   req_aluc,
  output logic [1:0]            rsp_valid,
  input  logic [1:0]            rsp_ready,
  output logic [WIDTH-1:0]      rsp_r,
  output logic                  rsp_z,
  output logic [WIDTH-1:0]      alu_x,
  output logic [WIDTH-1:0]      alu_y,
  output logic [ALUC_W-1:0]     alu_aluc,
  input  logic [WIDTH-1:0]      alu_r,
  input  logic                  alu_z
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]           grant_cnt0,
  output logic [15:0]           grant_cnt1
`endif
);

  arb_state_e          state_r;
  logic                last_grant_r;
  logic                owner_r;
  logic [WIDTH-1:0]    op_x_r;
  logic [WIDTH-1:0]    op_y_r;
  logic [ALUC_W-1:0]   op_aluc_r;
  logic [WIDTH-1:0]    res_r;
  logic                res_z_r;

  logic                grant_valid_s;
  logic                grant_s;
  logic                accept_s;
  logic [WIDTH-1:0]    sel_x_s;
  logic [WIDTH-1:0]    sel_y_s;
  logic [ALUC_W-1:0]   sel_aluc_s;

  rr_arb2 u_rr_arb2 (
    .req_valid   (req_valid),
    .last_grant  (last_grant_r),
    .grant_valid (grant_valid_s),
    .grant       (grant_s)
  );

  // A grant only turns into an accept while idle
  assign accept_s = (state_r == ST_IDLE) && grant_valid_s;

  // Operand select for the winning requester
  always_comb begin
    if (grant_s == REQ1) begin
      sel_x_s    = req_x[WIDTH +: WIDTH];
      sel_y_s    = req_y[WIDTH +: WIDTH];
      sel_aluc_s = req_aluc[ALUC_W +: ALUC_W];
    end else begin
      sel_x_s    = req_x[0 +: WIDTH];
      sel_y_s    = req_y[0 +: WIDTH];
      sel_aluc_s = req_aluc[0 +: ALUC_W];
    end
  end

  // Handshake decode from registered state
  always_comb begin
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    if (accept_s) begin
      req_ready[grant_s] = 1'b1;
    end else begin
      req_ready = 2'b00;
    end
    if (state_r == ST_RESP) begin
      rsp_valid[owner_r] = 1'b1;
    end else begin
      rsp_valid = 2'b00;
    end
  end

  // Arbitration FSM and datapath registers
  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_r      <= ST_IDLE;
      last_grant_r <= REQ1;
      owner_r      <= REQ0;
      op_x_r       <= '0;
      op_y_r       <= '0;
      op_aluc_r    <= '0;
      res_r        <= '0;
      res_z_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            op_x_r       <= sel_x_s;
            op_y_r       <= sel_y_s;
            op_aluc_r    <= sel_aluc_s;
            owner_r      <= grant_s;
            last_grant_r <= grant_s;
            state_r      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          res_r   <= alu_r;
          res_z_r <= alu_z;
          state_r <= ST_RESP;
        end
        ST_RESP: begin
          // Only the owner's rsp_ready can retire the result
          if (rsp_ready[owner_r]) begin
            state_r <= ST_IDLE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign alu_x    = op_x_r;
  assign alu_y    = op_y_r;
  assign alu_aluc = op_aluc_r;
  assign rsp_r    = res_r;
  assign rsp_z    = res_z_r;

`ifdef ALU_ARB_STATS_EN
  logic [15:0] cnt0_r;
  logic [15:0] cnt1_r;

  // Per-requester accept counters, wrapping at 16 bits
  always_ff @(posedge clk) begin
    if (!clrn) begin
      cnt0_r <= 16'd0;
      cnt1_r <= 16'd0;
    end else if (accept_s) begin
      if (grant_s == REQ1) begin
        cnt1_r <= cnt1_r + 16'd1;
      end else begin
        cnt0_r <= cnt0_r + 16'd1;
      end
    end
  end

  assign grant_cnt0 = cnt0_r;
  assign grant_cnt1 = cnt1_r;
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// Scoreboard bench for alu_share_arb with a behavioural ALU on the alu_* side.
module tb_alu_share_arb;
  import alu_arb_pkg::*;

  localparam int W  = 32;
  localparam int AW = 4;

  logic              clk = 1'b0;
  logic              clrn;
  logic [1:0]        req_valid, req_ready, rsp_valid, rsp_ready;
  logic [2*W-1:0]    req_x, req_y;
  logic [2*AW-1:0]   req_aluc;
  logic [W-1:0]      rsp_r, alu_x, alu_y, alu_r;
  logic              rsp_z, alu_z;
  logic [AW-1:0]     alu_aluc;
`ifdef ALU_ARB_STATS_EN
  logic [15:0]       grant_cnt0, grant_cnt1;
`endif

  typedef struct packed {
    logic          idx;
    logic [W-1:0]  r;
    logic          z;
  } exp_t;

  exp_t sb[$];
  int   grant_log[$];
  int   ops_left[2];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  function automatic logic [W-1:0] alu_fn(logic [W-1:0] a, logic [W-1:0] b, logic [AW-1:0] c);
    case (c)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      default: return a ^ b;
    endcase
  endfunction

  assign alu_r = alu_fn(alu_x, alu_y, alu_aluc);
  assign alu_z = (alu_r == '0);

  alu_share_arb dut (
    .clk       (clk),
    .clrn      (clrn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_aluc  (req_aluc),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_r     (rsp_r),
    .rsp_z     (rsp_z),
    .alu_x     (alu_x),
    .alu_y     (alu_y),
    .alu_aluc  (alu_aluc),
    .alu_r     (alu_r),
    .alu_z     (alu_z)
`ifdef ALU_ARB_STATS_EN
    ,
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] x, input logic [W-1:0] y, input logic [AW-1:0] c);
    req_x[i*W +: W]       = x;
    req_y[i*W +: W]       = y;
    req_aluc[i*AW +: AW]  = c;
    req_valid[i]          = 1'b1;
  endtask

  // One isolated operation with cycle-exact latency checks
  task automatic single_op(input int i, input logic [W-1:0] x, input logic [W-1:0] y, input logic [AW-1:0] c);
    logic [W-1:0] r;
    logic [1:0]   onehot;
    r = alu_fn(x, y, c);
    onehot = 2'b01 << i;
    set_req(i, x, y, c);
    #1;
    check_eq("single_ready", req_ready, onehot);
    tick();
    req_valid[i] = 1'b0;
    #1;
    check_eq("exec_ready", req_ready, 2'b00);
    check_eq("exec_rspv", rsp_valid, 2'b00);
    check_eq("exec_alu_x", alu_x, x);
    check_eq("exec_alu_aluc", alu_aluc, c);
    tick();
    check_eq("single_rspv", rsp_valid, onehot);
    check_eq("single_r", rsp_r, r);
    check_eq("single_z", rsp_z, (r == '0));
    rsp_ready = onehot;
    tick();
    rsp_ready = 2'b00;
    #1;
    check_eq("single_done", rsp_valid, 2'b00);
  endtask

  initial begin
    int   gi;
    logic [1:0] acc, take;
    exp_t e;
    logic [W-1:0] hold_r;

    clrn = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00;
    req_x = '0; req_y = '0; req_aluc = '0;

    // Reset and idle
    tick(); tick();
    check_eq("rst_ready", req_ready, 2'b00);
    check_eq("rst_rspv", rsp_valid, 2'b00);
    check_eq("rst_r", rsp_r, 32'd0);
    check_eq("rst_z", rsp_z, 1'b0);
    check_eq("rst_alu_x", alu_x, 32'd0);
    check_eq("rst_alu_y", alu_y, 32'd0);
    check_eq("rst_alu_aluc", alu_aluc, 4'd0);
    clrn = 1'b1;
    tick(); tick(); tick();
    check_eq("idle_ready", req_ready, 2'b00);
    check_eq("idle_rspv", rsp_valid, 2'b00);

    // Single add, then zero result on requester 1
    single_op(0, 32'd5, 32'd3, 4'd0);
    single_op(1, 32'd7, 32'd7, 4'd1);

    // Contention: both requesters continuously valid
    ops_left[0] = 3; ops_left[1] = 3;
    set_req(0, $urandom, $urandom, 4'($urandom_range(0, 5)));
    set_req(1, $urandom, $urandom, 4'($urandom_range(0, 5)));
    rsp_ready = 2'b11;
    #1;
    for (int cyc = 0; cyc < 200 && ((ops_left[0] + ops_left[1]) > 0 || sb.size() > 0); cyc++) begin
      acc  = req_ready & req_valid;
      take = rsp_valid & rsp_ready;
      check_eq("rdy_onehot", {63'd0, ($countones(req_ready) <= 1)}, 64'd1);
      if (take != 2'b00) begin
        if (sb.size() == 0) begin
          check_eq("rsp_unexpected", take, 2'b00);
        end else begin
          e = sb.pop_front();
          check_eq("rsp_route", rsp_valid, 2'b01 << e.idx);
          check_eq("rsp_r", rsp_r, e.r);
          check_eq("rsp_z", rsp_z, e.z);
        end
      end
      gi = acc[1] ? 1 : 0;
      if (acc != 2'b00) begin
        e.idx = gi[0];
        e.r   = alu_fn(req_x[gi*W +: W], req_y[gi*W +: W], req_aluc[gi*AW +: AW]);
        e.z   = (e.r == '0);
        sb.push_back(e);
        grant_log.push_back(gi);
        ops_left[gi]--;
      end
      tick();
      if (acc != 2'b00) begin
        if (ops_left[gi] > 0) set_req(gi, $urandom, $urandom, 4'($urandom_range(0, 5)));
        else req_valid[gi] = 1'b0;
      end
      #1;
    end
    check_eq("contention_done", ops_left[0] + ops_left[1] + sb.size(), 0);
    check_eq("grant_count", grant_log.size(), 6);
    for (int k = 0; k < grant_log.size(); k++) begin
      check_eq($sformatf("grant_order%0d", k), grant_log[k], k % 2);
    end
    rsp_ready = 2'b00;
    req_valid = 2'b00;
    tick();

    // Backpressure: result held while only the non-owner signals ready
    set_req(0, 32'h1234, 32'h0F0F, 4'd2);
    #1;
    check_eq("bp_accept", req_ready, 2'b01);
    tick();
    req_valid[0] = 1'b0;
    set_req(1, 32'd9, 32'd9, 4'd0);
    tick();
    hold_r = alu_fn(32'h1234, 32'h0F0F, 4'd2);
    rsp_ready = 2'b10;
    for (int c = 0; c < 5; c++) begin
      check_eq("bp_rspv", rsp_valid, 2'b01);
      check_eq("bp_r", rsp_r, hold_r);
      check_eq("bp_alu_x", alu_x, 32'h1234);
      check_eq("bp_alu_y", alu_y, 32'h0F0F);
      check_eq("bp_ready", req_ready, 2'b00);
      tick();
    end
    req_valid = 2'b00;
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    #1;
    check_eq("bp_release", rsp_valid, 2'b00);

`ifdef ALU_ARB_STATS_EN
    check_eq("cnt0", grant_cnt0, 16'd5);
    check_eq("cnt1", grant_cnt1, 16'd4);
`endif

    // Reset during EXEC drops the op and restores requester-0 priority
    set_req(1, 32'd1, 32'd2, 4'd0);
    #1;
    check_eq("mid_accept", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    clrn = 1'b0;
    set_req(0, 32'd4, 32'd4, 4'd0);
    set_req(1, 32'd6, 32'd6, 4'd0);
    tick();
    clrn = 1'b1;
    #1;
    check_eq("mid_rspv", rsp_valid, 2'b00);
    check_eq("mid_r", rsp_r, 32'd0);
    check_eq("mid_alu_x", alu_x, 32'd0);
    check_eq("mid_last_grant", req_ready, 2'b01);
`ifdef ALU_ARB_STATS_EN
    check_eq("mid_cnt0", grant_cnt0, 16'd0);
    check_eq("mid_cnt1", grant_cnt1, 16'd0);
`endif
    req_valid = 2'b00;
    for (int c = 0; c < 4; c++) begin
      tick();
      check_eq("mid_no_rsp", rsp_valid, 2'b00);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
